signaldelay_ctrl: RTL and testbench

Configuration sequencer for a bank of NCH 512-deep signal delay lines. It accepts delay writes from the register interface and applies them to one channel at a time. For each channel update it flushes the channel's delay FIFO, loads the new delay, and then holds that channel's output-valid flag low until the line has refilled. It sits between the register map and the delay-line instances, so host writes never corrupt in-flight delayed signals.

---
 rtl/signaldelay_pkg.sv | 24 ++
 rtl/signaldelay_rr_arb.sv | 40 ++++
 rtl/signaldelay_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_signaldelay_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/signaldelay_pkg.sv
// signaldelay_pkg
// Shared definitions for the delay-line configuration sequencer.
// Holds the default delay word width and largest legal delay (the same
// values the signaldelay512 delay lines are built with), the default
// channel count and flush length, and the sequencer state encoding.
// No ports: this file is imported by signaldelay_ctrl and
// signaldelay_rr_arb.

package signaldelay_pkg;

  localparam int SD_NCH       = 8;
  localparam int SD_DW        = 10;
  localparam int SD_MAXDELAY  = 511;
  localparam int SD_FLUSH_CYC = 4;

  // Encoding is fixed so the state can be decoded from a debug port.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLUSH  = 2'd1,
    LOAD   = 2'd2,
    SETTLE = 2'd3
  } sd_state_e;

endpackage

// File: rtl/signaldelay_rr_arb.sv
// signaldelay_rr_arb
// Purely combinational round-robin arbiter over the pending channels.
// The search starts at the channel after 'last' and wraps around, so the
// channel that was just serviced has the lowest priority next time.
// Ports:
//   req     - one request bit per channel
//   last    - index of the most recently serviced channel
//   gnt_idx - index of the granted channel (0 when nothing is requested)
//   gnt_vld - high when at least one request bit is set

module signaldelay_rr_arb
  import signaldelay_pkg::*;
#(
  parameter  int NCH = SD_NCH,
  localparam int AW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0] req,
  input  logic [AW-1:0]  last,
  output logic [AW-1:0]  gnt_idx,
  output logic           gnt_vld
);

  // Walk the channels in order last+1, last+2, ... wrapping modulo NCH and
  // pick the first one that is requesting. Visiting 'last' itself at the
  // very end lets a lone requester be re-granted.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = 1; i <= NCH; i++) begin
      idx = (int'(last) + i) % NCH;
      if (!gnt_vld && req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = AW'(idx);
      end
    end
  end

endmodule

// File: rtl/signaldelay_ctrl.sv
// signaldelay_ctrl
// Configuration sequencer for a bank of NCH delay lines. Host writes land in
// per-channel shadow registers and raise a pending bit; a round-robin
// scheduler then walks the pending channels one at a time, flushing the
// channel's FIFO, loading the new delay and holding its ready flag low until
// the line has refilled.
// Ports:
//   clk, rst_n - system clock, asynchronous active-low reset
//   wr_en      - host write strobe (one cycle per write)
//   wr_addr    - target channel; addresses >= NCH are rejected
//   wr_data    - requested delay in clk cycles (clamped to MAXDELAY)
//   err_clr    - clears the sticky error flag
//   delay_bus  - applied delay per channel, channel k at [k*DW +: DW]
//   flush      - per-channel FIFO synchronous reset
//   ready      - per-channel output-valid flag, low while refilling
//   busy       - sequencer active or any channel still pending
//   err        - sticky flag for clamped writes and bad addresses

module signaldelay_ctrl
  import signaldelay_pkg::*;
#(
  parameter  int NCH       = SD_NCH,
  parameter  int DW        = SD_DW,
  parameter  int MAXDELAY  = SD_MAXDELAY,
  parameter  int FLUSH_CYC = SD_FLUSH_CYC,
  localparam int AW        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DW-1:0]     wr_data,
  input  logic              err_clr,
  output logic [NCH*DW-1:0] delay_bus,
  output logic [NCH-1:0]    flush,
  output logic [NCH-1:0]    ready,
  output logic              busy,
  output logic              err
);

  localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  // One extra bit so target+2 never wraps, even at MAXDELAY.
  localparam int CW = DW + 1;

  sd_state_e         state_q, state_d;
  logic [AW-1:0]     ch_q, ch_d;
  logic [AW-1:0]     last_q, last_d;
  logic [DW-1:0]     target_q, target_d;
  logic [FW-1:0]     fcnt_q, fcnt_d;
  logic [CW-1:0]     scnt_q, scnt_d;
  logic [DW-1:0]     shadow_q [NCH];
  logic [DW-1:0]     shadow_d [NCH];
  logic [NCH-1:0]    pend_q, pend_d;
  logic [NCH*DW-1:0] delay_q, delay_d;
  logic [NCH-1:0]    flush_q, flush_d;
  logic [NCH-1:0]    ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  logic              wr_ok;
  logic              wr_clamp;
  logic [DW-1:0]     wr_val;
  logic [AW-1:0]     gnt_idx;
  logic              gnt_vld;
  logic              grant;

  assign wr_ok    = wr_en && ({1'b0, wr_addr} < (AW+1)'(NCH));
  assign wr_clamp = wr_data > DW'(MAXDELAY);
  assign wr_val   = wr_clamp ? DW'(MAXDELAY) : wr_data;
  assign grant    = (state_q == IDLE) && gnt_vld;

  signaldelay_rr_arb #(
    .NCH (NCH)
  ) u_arb (
    .req     (pend_q),
    .last    (last_q),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  // Host side: shadow registers, pending bits and the sticky error flag.
  // The write is applied after the grant clear so a write to the channel
  // being picked up in the same cycle keeps its pending bit and gets
  // sequenced again. An error event overrides a simultaneous err_clr.
  always_comb begin
    shadow_d = shadow_q;
    pend_d   = pend_q;
    err_d    = err_q;
    if (grant) begin
      pend_d[gnt_idx] = 1'b0;
    end
    if (wr_ok) begin
      shadow_d[wr_addr] = wr_val;
      pend_d[wr_addr]   = 1'b1;
    end
    if (err_clr) begin
      err_d = 1'b0;
    end
    if (wr_en && (!wr_ok || wr_clamp)) begin
      err_d = 1'b1;
    end
  end

  // Sequencer: IDLE picks a pending channel and latches its shadow value so
  // later host writes cannot disturb the sequence in flight. FLUSH holds the
  // FIFO reset for FLUSH_CYC cycles, LOAD publishes the delay, and SETTLE
  // waits target+2 cycles for the line to refill before raising ready.
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    last_d   = last_q;
    target_d = target_q;
    fcnt_d   = fcnt_q;
    scnt_d   = scnt_q;
    delay_d  = delay_q;
    flush_d  = flush_q;
    ready_d  = ready_q;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          ch_d             = gnt_idx;
          last_d           = gnt_idx;
          target_d         = shadow_q[gnt_idx];
          fcnt_d           = FW'(FLUSH_CYC - 1);
          flush_d[gnt_idx] = 1'b1;
          ready_d[gnt_idx] = 1'b0;
          state_d          = FLUSH;
        end
      end
      FLUSH: begin
        if (fcnt_q == '0) begin
          flush_d[ch_q] = 1'b0;
          state_d       = LOAD;
        end else begin
          fcnt_d = fcnt_q - FW'(1);
        end
      end
      LOAD: begin
        delay_d[ch_q*DW +: DW] = target_q;
        scnt_d                 = {1'b0, target_q} + CW'(2);
        state_d                = SETTLE;
      end
      SETTLE: begin
        // Decrement-then-test: the cycle that takes the count to zero is
        // the one that raises ready.
        scnt_d = scnt_q - CW'(1);
        if (scnt_q == CW'(1)) begin
          ready_d[ch_q] = 1'b1;
          state_d       = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // busy looks at next-state values so it rises in the same cycle as the
  // pending bit and falls in the same cycle as the final ready.
  assign busy_d = (state_d != IDLE) || (|pend_d);

  // All state and every output is registered here; reset drops any sequence
  // in flight and returns every channel to ready with a zero delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ch_q     <= '0;
      last_q   <= '0;
      target_q <= '0;
      fcnt_q   <= '0;
      scnt_q   <= '0;
      for (int k = 0; k < NCH; k++) begin
        shadow_q[k] <= '0;
      end
      pend_q   <= '0;
      delay_q  <= '0;
      flush_q  <= '0;
      ready_q  <= '1;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      last_q   <= last_d;
      target_q <= target_d;
      fcnt_q   <= fcnt_d;
      scnt_q   <= scnt_d;
      for (int k = 0; k < NCH; k++) begin
        shadow_q[k] <= shadow_d[k];
      end
      pend_q   <= pend_d;
      delay_q  <= delay_d;
      flush_q  <= flush_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  assign delay_bus = delay_q;
  assign flush     = flush_q;
  assign ready     = ready_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_signaldelay_ctrl.sv
// tb_signaldelay_ctrl
// Bench for signaldelay_ctrl with NCH=6 so that addresses 6 and 7 are out
// of range. A transaction-level model tracks shadow values, pending
// channels and the timeline of the channel being sequenced; each time it
// starts a sequence it pushes the expected completion (channel, delay, edge
// of ready rise) into a queue. A separate monitor compares every output each
// cycle and consumes one queue entry whenever a ready bit rises.

module tb_signaldelay_ctrl;

  localparam int NCH       = 6;
  localparam int DW        = 10;
  localparam int MAXDELAY  = 511;
  localparam int FLUSH_CYC = 4;
  localparam int AW        = 3;

  typedef struct {
    int ch;
    int delay;
    int edgeNo;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic              err_clr;
  logic [NCH*DW-1:0] delay_bus;
  logic [NCH-1:0]    flush;
  logic [NCH-1:0]    ready;
  logic              busy;
  logic              err;

  int checks = 0;
  int errors = 0;
  bit waitExpired = 1'b0;
  bit finalCheck = 1'b0;

  always #5 clk = ~clk;

  signaldelay_ctrl #(
    .NCH       (NCH),
    .DW        (DW),
    .MAXDELAY  (MAXDELAY),
    .FLUSH_CYC (FLUSH_CYC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .err_clr   (err_clr),
    .delay_bus (delay_bus),
    .flush     (flush),
    .ready     (ready),
    .busy      (busy),
    .err       (err)
  );

  // Reference model state.
  int           mShadow [NCH];
  int           mDelay [NCH];
  bit [NCH-1:0] mPend;
  bit [NCH-1:0] mFlush;
  bit [NCH-1:0] mReady = '1;
  int           mLast;
  int           mCh;
  int           mTarget;
  int           mGrant;
  int           mEdge = 0;
  bit           mActive;
  bit           mBusy;
  bit           mErr;
  exp_t         expQ [$];

  // Model: one channel at a time; a sequence granted at edge g raises flush
  // at g, drops it at g+FLUSH_CYC, publishes the delay at g+FLUSH_CYC+1 and
  // raises ready at g+FLUSH_CYC+3+target. Grants only happen from an idle
  // cycle, in round-robin order after the last serviced channel.
  always @(posedge clk or negedge rst_n) begin : model
    int  k;
    int  c;
    bit  found;
    bit  errEvt;
    int  a;
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        mShadow[i] = 0;
        mDelay[i]  = 0;
      end
      mPend   = '0;
      mFlush  = '0;
      mReady  = '1;
      mLast   = 0;
      mCh     = 0;
      mTarget = 0;
      mGrant  = 0;
      mActive = 1'b0;
      mBusy   = 1'b0;
      mErr    = 1'b0;
    end else begin
      mEdge++;
      if (mActive) begin
        k = mEdge - mGrant;
        if (k == FLUSH_CYC) mFlush[mCh] = 1'b0;
        if (k == FLUSH_CYC + 1) mDelay[mCh] = mTarget;
        if (k == FLUSH_CYC + 3 + mTarget) begin
          mReady[mCh] = 1'b1;
          mActive     = 1'b0;
        end
      end else begin
        found = 1'b0;
        for (int i = 1; i <= NCH; i++) begin
          c = (mLast + i) % NCH;
          if (!found && mPend[c]) begin
            found      = 1'b1;
            mCh        = c;
            mTarget    = mShadow[c];
            mPend[c]   = 1'b0;
            mLast      = c;
            mGrant     = mEdge;
            mFlush[c]  = 1'b1;
            mReady[c]  = 1'b0;
            mActive    = 1'b1;
            expQ.push_back('{ch: c, delay: mTarget,
                             edgeNo: mEdge + FLUSH_CYC + 3 + mTarget});
          end
        end
      end
      errEvt = 1'b0;
      if (wr_en) begin
        a = int'(wr_addr);
        if (a >= NCH) begin
          errEvt = 1'b1;
        end else begin
          if (int'(wr_data) > MAXDELAY) begin
            errEvt     = 1'b1;
            mShadow[a] = MAXDELAY;
          end else begin
            mShadow[a] = int'(wr_data);
          end
          mPend[a] = 1'b1;
        end
      end
      if (err_clr) mErr = 1'b0;
      if (errEvt) mErr = 1'b1;
      mBusy = mActive || (mPend != '0);
    end
  end

  // Single comparison point: counts the check and reports any mismatch.
  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s at edge %0d: got %0h expected %0h", name, mEdge,
               act, expv);
    end
  endtask

  int           rdIdx = 0;
  bit [NCH-1:0] prevReady = '1;
  bit           timeoutReported = 1'b0;
  bit           drainDone = 1'b0;

  // Monitor: samples 1 time unit after each clock edge or reset assertion.
  always begin : monitor
    logic [NCH*DW-1:0] expBus;
    exp_t              e;
    @(posedge clk or negedge rst_n);
    #1;
    if (!rst_n) begin
      checkOutput("reset_delay_bus", 64'(delay_bus), 64'd0);
      checkOutput("reset_flush", 64'(flush), 64'd0);
      checkOutput("reset_ready", 64'(ready), 64'h3f);
      checkOutput("reset_busy", 64'(busy), 64'd0);
      checkOutput("reset_err", 64'(err), 64'd0);
      rdIdx     = expQ.size();
      prevReady = '1;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        expBus[k*DW +: DW] = DW'(mDelay[k]);
      end
      checkOutput("delay_bus", 64'(delay_bus), 64'(expBus));
      checkOutput("flush", 64'(flush), 64'(mFlush));
      checkOutput("ready", 64'(ready), 64'(mReady));
      checkOutput("busy", 64'(busy), 64'(mBusy));
      checkOutput("err", 64'(err), 64'(mErr));
      for (int k = 0; k < NCH; k++) begin
        if (!prevReady[k] && ready[k]) begin
          if (rdIdx >= expQ.size()) begin
            checks++;
            errors++;
            $display("[TB] FAIL seq_unexpected: ready[%0d] rose at edge %0d, required no completion",
                     k, mEdge);
          end else begin
            e = expQ[rdIdx];
            rdIdx++;
            checkOutput("seq_channel", 64'(k), 64'(e.ch));
            checkOutput("seq_edge", 64'(mEdge), 64'(e.edgeNo));
            checkOutput("seq_delay", 64'(delay_bus[k*DW +: DW]), 64'(e.delay));
          end
        end
      end
      prevReady = ready;
      if (waitExpired && !timeoutReported) begin
        timeoutReported = 1'b1;
        checks++;
        errors++;
        $display("[TB] FAIL idle_timeout: busy still %0b, required 0", busy);
      end
      if (finalCheck && !drainDone) begin
        drainDone = 1'b1;
        checkOutput("queue_drained", 64'(rdIdx), 64'(expQ.size()));
      end
    end
  end

  // Drives one cycle of inputs starting at the current falling edge.
  task automatic applyStimulus(input bit we, input int addr, input int data,
                               input bit clr);
    wr_en   = we;
    wr_addr = AW'(addr);
    wr_data = DW'(data);
    err_clr = clr;
    @(negedge clk);
    wr_en   = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic waitIdle(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    waitExpired = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    err_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] single write ch2=100");
    applyStimulus(1, 2, 100, 0);
    waitIdle(400);

    $display("[TB] clamp and bad address");
    applyStimulus(1, 0, 1000, 0);
    waitIdle(700);
    applyStimulus(1, 7, 100, 0);
    applyStimulus(1, 6, 5, 0);
    repeat (3) @(negedge clk);
    applyStimulus(0, 0, 0, 1);
    repeat (2) @(negedge clk);

    $display("[TB] round robin");
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 5, 0, 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 3, 0, 0);
    waitIdle(200);

    $display("[TB] rewrite during settle");
    applyStimulus(1, 4, 50, 0);
    repeat (20) @(negedge clk);
    applyStimulus(1, 4, 20, 0);
    waitIdle(300);

    $display("[TB] reset mid-sequence");
    applyStimulus(1, 1, 30, 0);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] edge delays");
    applyStimulus(1, 5, 0, 0);
    waitIdle(100);
    applyStimulus(1, 5, 511, 0);
    waitIdle(700);

    $display("[TB] randomized writes");
    for (int n = 0; n < 45; n++) begin
      int a;
      int d;
      bit c;
      a = int'($urandom_range(7, 0));
      if ($urandom_range(3, 0) == 0) d = int'($urandom_range(1023, 0));
      else d = int'($urandom_range(40, 0));
      c = ($urandom_range(7, 0) == 0);
      applyStimulus(1, a, d, c);
      repeat ($urandom_range(12, 0)) @(negedge clk);
      if ($urandom_range(9, 0) == 0) applyStimulus(0, 0, 0, 1);
    end
    waitIdle(40000);

    finalCheck = 1'b1;
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
